// File: rtl/mux_bus_responder_if.sv
// rtl/mux_bus_responder_if.sv - memory-side request/response bus of the mux bus responder
//
// Signals:
//   mem_req    responder -> memory  request, held until mem_ready
//   mem_we     responder -> memory  1 = write, 0 = read
//   mem_addr   responder -> memory  request address
//   mem_wdata  responder -> memory  write data
//   mem_ready  memory -> responder  request accepted
//   mem_rvalid memory -> responder  read data valid
//   mem_rdata  memory -> responder  read data
// Modports: master (the responder), slave (the memory).
interface mux_bus_responder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2 * DATA_WIDTH
) ();
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mux_bus_responder.sv
// rtl/mux_bus_responder.sv - deserialises the 3-phase CPU mux bus and serves one memory transaction per CPU cycle
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset, shared with the CPU wrapper
//   mux_bus        multiplexed bus: address low, address high, {.., SYNC, RW}
//   cpu_data_out   CPU write data, sampled when a frame completes
//   cpu_data_oe    CPU data output enables (not needed to decide writes; RW does that)
//   cpu_data_in    last read data returned to the CPU
//   cpu_rdy        low while a read is outstanding
//   frame_*        decoded frame: one-cycle valid pulse, address, RW, SYNC
//   mem            memory request/response bus (master side)
//   overrun        sticky flag: an issue frame arrived while busy
//   overrun_clr    clears overrun (a simultaneous new overrun wins)
module mux_bus_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   mux_bus,
    input  logic [DATA_WIDTH-1:0]   cpu_data_out,
    input  logic [DATA_WIDTH-1:0]   cpu_data_oe,
    output logic [DATA_WIDTH-1:0]   cpu_data_in,
    output logic                    cpu_rdy,
    output logic                    frame_valid,
    output logic [ADDR_WIDTH-1:0]   frame_addr,
    output logic                    frame_rw,
    output logic                    frame_sync,
    mux_bus_responder_if.master     mem,
    output logic                    overrun,
    input  logic                    overrun_clr
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t                state;
    logic [1:0]            phase;
    logic                  primed;
    logic                  cpu_clk_mirror;
    logic                  half_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [DATA_WIDTH-1:0] hi_q;

    logic frame_done;
    logic issue;
    logic txn_done;
    logic can_accept;
    logic unused_inputs;

    // Output enables carry no information the RW bit does not already give.
    assign unused_inputs = &{1'b0, cpu_data_oe};

    always_comb begin
        frame_done = 1'b0;
        issue      = 1'b0;
        txn_done   = 1'b0;
        can_accept = 1'b0;
        frame_done = (phase == 2'd0) && primed;
        // Only the second half of each CPU cycle carries a frame worth serving.
        issue      = frame_done && half_q;
        txn_done   = ((state == REQ) && mem.mem_ready && mem.mem_we) ||
                     ((state == WAIT_R) && mem.mem_rvalid);
        // A transaction finishing on this edge frees the slot for the new frame.
        can_accept = (state == IDLE) || txn_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            phase          <= 2'd0;
            primed         <= 1'b0;
            cpu_clk_mirror <= 1'b0;
            half_q         <= 1'b0;
            lo_q           <= '0;
            hi_q           <= '0;
            cpu_data_in    <= '0;
            cpu_rdy        <= 1'b1;
            frame_valid    <= 1'b0;
            frame_addr     <= '0;
            frame_rw       <= 1'b0;
            frame_sync     <= 1'b0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            overrun        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            phase       <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            if (phase == 2'd2) begin
                cpu_clk_mirror <= ~cpu_clk_mirror;
            end

            case (phase)
                2'd1: begin
                    lo_q   <= mux_bus;
                    half_q <= cpu_clk_mirror;
                end
                2'd2: begin
                    hi_q   <= mux_bus;
                    primed <= 1'b1;
                end
                default: ;
            endcase

            if (frame_done) begin
                frame_valid <= 1'b1;
                frame_addr  <= {hi_q, lo_q};
                frame_rw    <= mux_bus[0];
                frame_sync  <= mux_bus[1];
            end

            if (overrun_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                REQ: begin
                    if (mem.mem_ready) begin
                        mem.mem_req <= 1'b0;
                        state       <= mem.mem_we ? IDLE : WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (mem.mem_rvalid) begin
                        cpu_data_in <= mem.mem_rdata;
                        cpu_rdy     <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: ;
            endcase

            // Placed last so a new request overrides the completion updates above.
            if (issue) begin
                if (can_accept) begin
                    state         <= REQ;
                    mem.mem_req   <= 1'b1;
                    mem.mem_addr  <= {hi_q, lo_q};
                    mem.mem_we    <= ~mux_bus[0];
                    mem.mem_wdata <= cpu_data_out;
                    cpu_rdy       <= ~mux_bus[0];
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/mux_bus_responder.md
Name: mux_bus_responder

Overview:
- Board/FPGA-side companion to the tinymos6502 time-multiplexed output bus.
- Deserialises the 3-phase stream (address low, address high, RW/SYNC) back into full bus frames, using a phase counter locked from the shared reset.
- Turns one frame per 6502 cycle into a memory transaction, returns read data onto the CPU data-input pins, and holds CPU RDY low while a read is outstanding.

Parameters:
- ADDR_WIDTH, 16, reconstructed address width; fixed at 2 × DATA_WIDTH.
- DATA_WIDTH, 8, multiplexed bus and data width.

Ports:
- clk  in  1  same clock as the CPU wrapper.
- rst_n  in  1  reset, asynchronous, active-low; must be the same reset as the CPU wrapper.
- mux_bus  in  8  multiplexed output bus from the CPU wrapper.
- cpu_data_out  in  8  CPU data-out pins (write data).
- cpu_data_oe  in  8  CPU data output-enable pins.
- cpu_data_in  out  8  read data driven to the CPU data-in pins.
- cpu_rdy  out  1  RDY to the CPU.
- frame_valid  out  1  one-cycle pulse; a frame has been decoded.
- frame_addr  out  16  decoded address.
- frame_rw  out  1  decoded RW (1 = read).
- frame_sync  out  1  decoded SYNC.
- mem_req  out  1  memory request; held until accepted.
- mem_we  out  1  1 = write.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_ready  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  8  read data.
- overrun  out  1  sticky; a frame arrived while the responder was busy.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset: all outputs 0, except cpu_rdy = 1. phase = 0, primed = 0, cpu_clk_mirror = 0, state = IDLE.
- phase counter: counts 0→1→2→0 on every clk edge; mirrors the transmitter's divider.
- cpu_clk_mirror: toggles on every edge where phase == 2.
- Captures, on the edge taken in the named phase:
  - phase 1: lo_q <= mux_bus; half_q <= cpu_clk_mirror.
  - phase 2: hi_q <= mux_bus; primed <= 1.
  - phase 0 with primed = 1: rw = mux_bus[0], sync = mux_bus[1]; wdata_q <= cpu_data_out. This completes the frame.
  - phase 0 with primed = 0 (first edge after reset): nothing captured; no frame.
- Frame completion outputs (registered, so valid the cycle after the capture edge):
  - frame_valid high for exactly 1 cycle.
  - frame_addr = {hi_q, lo_q}; frame_rw and frame_sync hold until the next frame.
  - mux_bus[7:2] are ignored during the control phase.
- Issue rule: a completed frame with half_q == 1 is an issue frame, i.e. one per 6502 cycle (frames 2, 4, 6, … after reset). Frames with half_q == 0 only produce frame_valid.
- FSM states: IDLE, REQ, WAIT_R.
  - IDLE + issue frame → REQ. Load mem_addr = frame address, mem_we = ~rw, mem_wdata = wdata_q; mem_req = 1.
  - REQ: mem_req held with address/data stable until mem_ready. On mem_ready: write → IDLE; read → WAIT_R. mem_req drops the cycle after mem_ready.
  - WAIT_R: on mem_rvalid, cpu_data_in <= mem_rdata, → IDLE. mem_rvalid is ignored in every other state.
- cpu_rdy = 0 whenever a read is in REQ or WAIT_R; otherwise 1.
- cpu_data_in holds its last read value until the next read completes.
- Boundary conditions:
  - Issue frame while state ≠ IDLE: frame is dropped and overrun <= 1. frame_valid still pulses.
  - Issue frame in the same cycle as a transaction completing (the transition to IDLE): the frame is accepted and goes straight to REQ; no overrun.
  - overrun_clr and a new overrun in the same cycle: overrun remains 1.
  - Write frame with cpu_data_oe ≠ 8'hFF: the write is still issued with the sampled cpu_data_out.
  - Reset mid-transaction: immediate return to reset values; mem_req drops asynchronously; the in-flight mem_rvalid is discarded.

Test Plan:
- Release reset, drive mux_bus = 8'h34 for the cycle before edge 2, 8'h12 before edge 3, 8'h01 before edge 4 → after edge 4: frame_valid pulses 1 cycle with frame_addr = 16'h1234, frame_rw = 1, frame_sync = 0; no mem_req (half 0).
- Second frame: 8'hFC, 8'hFF, 8'h03 → frame_addr = 16'hFFFC, sync = 1, mem_req = 1, mem_we = 0, cpu_rdy = 0. mem_ready on cycle 2, mem_rvalid with 8'hA9 on cycle 4 → cpu_data_in = 8'hA9, cpu_rdy = 1.
- Write issue frame: addr 16'h0200, ctrl 8'h00, cpu_data_out = 8'h5A, oe = 8'hFF → mem_we = 1, mem_addr = 16'h0200, mem_wdata = 8'h5A; cpu_rdy stays 1.
- Hold mem_ready low across the next issue frame → overrun = 1, the second frame is dropped, mem_addr is unchanged. Pulse overrun_clr → overrun = 0.
- Assert mem_rvalid in the same cycle an issue frame completes → the read completes and the new request is accepted; overrun stays 0.
- Assert rst_n low while in WAIT_R → mem_req = 0, cpu_rdy = 1, cpu_data_in = 0. After release, the first frame is decoded only at the 4th edge.
